// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: mode encodings, key indices,
// field limits and the press-priority / mode-stepping helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_t;

  localparam int KEY_MODE    = 0;
  localparam int KEY_INC     = 1;
  localparam int KEY_DEC     = 2;
  localparam int KEY_CONFIRM = 3;

  localparam int HOUR_MAX   = 23;
  localparam int MINSEC_MAX = 59;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CONFIRM,
    ACT_MODE,
    ACT_INC,
    ACT_DEC
  } action_t;

  // Only the highest-priority press survives; simultaneous lower ones are dropped.
  function automatic action_t pick_action(input logic [3:0] press);
    if (press[KEY_CONFIRM])  return ACT_CONFIRM;
    else if (press[KEY_MODE]) return ACT_MODE;
    else if (press[KEY_INC])  return ACT_INC;
    else if (press[KEY_DEC])  return ACT_DEC;
    else                      return ACT_NONE;
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_RUN:     return MODE_SET_HR;
      MODE_SET_HR:  return MODE_SET_MIN;
      MODE_SET_MIN: return MODE_SET_SEC;
      default:      return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_counter.sv
// Modulo-(MAX+1) up/down counter used for each time field; wrap flags an
// increment that rolls MAX over to 0 so the parent can chain carries.
module mod_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

  logic [WIDTH-1:0] r_q;

  // Combinational so the next field can advance on the same edge.
  assign wrap = inc & (r_q == MAX_Q);
  assign q    = r_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr)
      r_q <= '0;
    else if (inc)
      r_q <= (r_q == MAX_Q) ? '0 : r_q + 1'b1;
    else if (dec)
      r_q <= (r_q == '0) ? MAX_Q : r_q - 1'b1;
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day controller: key press detection, RUN/SET mode FSM with idle
// timeout and blink phase, and the chained HH:MM:SS counters.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  input  logic       tick_1hz,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] mode,
  output logic       blink
);

  localparam logic [5:0] TIMEOUT_Q = 6'(TIMEOUT_S);

  logic [3:0] r_key_prev;
  mode_t      r_mode;
  logic [5:0] r_idle_cnt;
  logic       r_blink_ph;

  logic [3:0] w_press;
  action_t    w_act;
  logic       w_in_set, w_edit_inc, w_edit_dec, w_blink_tog;
  logic       w_sec_inc, w_sec_dec, w_min_inc, w_min_dec, w_hr_inc, w_hr_dec;
  logic       w_sec_wrap, w_min_wrap, w_hr_wrap_unused;

  assign w_press     = r_key_prev & ~key_n;
  assign w_act       = pick_action(w_press);
  assign w_in_set    = (r_mode != MODE_RUN);
  assign w_edit_inc  = w_in_set & (w_act == ACT_INC);
  assign w_edit_dec  = w_in_set & (w_act == ACT_DEC);
  assign w_blink_tog = r_blink_ph ^ tick_1hz;

  // Carries only propagate in RUN; edits wrap within their own field.
  assign w_sec_inc = (~w_in_set & tick_1hz)   | (w_edit_inc & (r_mode == MODE_SET_SEC));
  assign w_sec_dec = w_edit_dec & (r_mode == MODE_SET_SEC);
  assign w_min_inc = (~w_in_set & w_sec_wrap) | (w_edit_inc & (r_mode == MODE_SET_MIN));
  assign w_min_dec = w_edit_dec & (r_mode == MODE_SET_MIN);
  assign w_hr_inc  = (~w_in_set & w_min_wrap) | (w_edit_inc & (r_mode == MODE_SET_HR));
  assign w_hr_dec  = w_edit_dec & (r_mode == MODE_SET_HR);

  mod_counter #(.WIDTH(6), .MAX(MINSEC_MAX)) u_sec (
    .clk(clk), .clr(rst), .inc(w_sec_inc), .dec(w_sec_dec), .q(second), .wrap(w_sec_wrap)
  );
  mod_counter #(.WIDTH(6), .MAX(MINSEC_MAX)) u_min (
    .clk(clk), .clr(rst), .inc(w_min_inc), .dec(w_min_dec), .q(minute), .wrap(w_min_wrap)
  );
  mod_counter #(.WIDTH(5), .MAX(HOUR_MAX)) u_hr (
    .clk(clk), .clr(rst), .inc(w_hr_inc), .dec(w_hr_dec), .q(hour), .wrap(w_hr_wrap_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_prev <= 4'b1111;
      r_mode     <= MODE_RUN;
      r_idle_cnt <= '0;
      r_blink_ph <= 1'b0;
    end else begin
      r_key_prev <= key_n;
      if (!w_in_set) begin
        r_idle_cnt <= '0;
        r_blink_ph <= 1'b0;
        if (w_act == ACT_MODE) r_mode <= MODE_SET_HR;
      end else if (w_act == ACT_CONFIRM) begin
        r_mode     <= MODE_RUN;
        r_idle_cnt <= '0;
        r_blink_ph <= 1'b0;
      end else if (w_act == ACT_MODE) begin
        r_mode     <= next_mode(r_mode);
        r_idle_cnt <= '0;
        r_blink_ph <= (r_mode == MODE_SET_SEC) ? 1'b0 : w_blink_tog;
      end else if (w_act != ACT_NONE) begin
        r_idle_cnt <= '0;
        r_blink_ph <= w_blink_tog;
      end else if (tick_1hz) begin
        // Leave on the tick that brings the idle count up to the limit.
        if (r_idle_cnt + 6'd1 == TIMEOUT_Q) begin
          r_mode     <= MODE_RUN;
          r_idle_cnt <= '0;
          r_blink_ph <= 1'b0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 6'd1;
          r_blink_ph <= w_blink_tog;
        end
      end
    end
  end

  // Blink phase is held at 0 in RUN, so it can drive the output directly.
  assign mode  = r_mode;
  assign blink = r_blink_ph;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl, built with a 3-second set-mode timeout.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_n;
  logic       tick_1hz;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] mode;
  logic       blink;

  int tests = 0;
  int fails = 0;

  clock_set_ctrl #(.TIMEOUT_S(3)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .tick_1hz(tick_1hz),
    .hour(hour), .minute(minute), .second(second), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle press of a single key followed by a release cycle.
  task automatic press(input int idx);
    key_n = 4'b1111;
    key_n[idx] = 1'b0;
    step();
    key_n = 4'b1111;
    step();
  endtask

  task automatic press_n(input int idx, input int n);
    for (int i = 0; i < n; i++) press(idx);
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    tests++;
    if (hour !== 5'(h) || minute !== 6'(m) || second !== 6'(s)) begin
      $display("FAIL %s: got %0d:%0d:%0d expected %0d:%0d:%0d", name, hour, minute, second, h, m, s);
      fails++;
    end
  endtask

  task automatic chk_mode(input string name, input int m, input logic b);
    tests++;
    if (mode !== 2'(m) || blink !== b) begin
      $display("FAIL %s: got mode=%0d blink=%b expected mode=%0d blink=%b", name, mode, blink, m, b);
      fails++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_n = 4'b1111;
    tick_1hz = 1'b0;
    repeat (3) step();
    chk_time("reset_time", 0, 0, 0);
    chk_mode("reset_mode", 0, 1'b0);
    rst = 1'b0;
    step();
  endtask

  task automatic test_set_sequence();
    press(0);
    chk_mode("enter_set_hr", 1, 1'b0);
    press_n(1, 3);
    chk_time("inc_hour_x3", 3, 0, 0);
    press(0);
    chk_mode("step_set_min", 2, 1'b0);
    press(2);
    chk_time("dec_min_wrap", 3, 59, 0);
    press(3);
    chk_mode("confirm_run", 0, 1'b0);
    tick();
    chk_time("run_resumes", 3, 59, 1);
  endtask

  task automatic test_held_key();
    press(0);
    key_n = 4'b1101;
    repeat (1000) step();
    key_n = 4'b1111;
    step();
    chk_time("held_inc_once", 4, 59, 1);
    press(3);
    chk_mode("held_confirm", 0, 1'b0);
  endtask

  task automatic test_simultaneous();
    press_n(0, 2);
    chk_mode("to_set_min", 2, 1'b0);
    key_n = 4'b0110;
    step();
    chk_mode("confirm_beats_mode", 0, 1'b0);
    chk_time("simul_min_kept", 4, 59, 1);
    key_n = 4'b1111;
    step();
  endtask

  task automatic test_rollover();
    press(0);
    press_n(2, 5);
    chk_time("hour_dec_wrap", 23, 59, 1);
    press_n(0, 2);
    press_n(1, 57);
    press(0);
    chk_mode("preset_run", 0, 1'b0);
    chk_time("preset", 23, 59, 58);
    tick();
    chk_time("tick_59", 23, 59, 59);
    tick();
    chk_time("midnight", 0, 0, 0);
  endtask

  task automatic test_edit_wrap();
    press_n(0, 3);
    chk_mode("to_set_sec", 3, 1'b0);
    press(2);
    chk_time("sec_dec_no_borrow", 0, 0, 59);
    press(1);
    chk_time("sec_inc_no_carry", 0, 0, 0);
    press(0);
    chk_mode("set_sec_to_run", 0, 1'b0);
  endtask

  task automatic test_tick_and_mode();
    key_n = 4'b1110;
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    key_n = 4'b1111;
    chk_time("tick_mode_time", 0, 0, 1);
    chk_mode("tick_mode_fsm", 1, 1'b0);
    step();
    press(3);
    chk_mode("tick_mode_confirm", 0, 1'b0);
  endtask

  task automatic test_timeout();
    press(0);
    chk_mode("timeout_enter", 1, 1'b0);
    tick();
    chk_mode("timeout_tick1", 1, 1'b1);
    tick();
    chk_mode("timeout_tick2", 1, 1'b0);
    tick();
    chk_mode("timeout_tick3", 0, 1'b0);
    chk_time("timeout_frozen", 0, 0, 1);
  endtask

  task automatic test_press_beats_timeout();
    press(0);
    tick();
    tick();
    key_n = 4'b1101;
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    key_n = 4'b1111;
    chk_mode("press_vs_timeout", 1, 1'b1);
    chk_time("press_vs_timeout_edit", 1, 0, 1);
    step();
    tick();
    chk_mode("idle_restarted", 1, 1'b0);
    press(3);
    chk_mode("pvt_confirm", 0, 1'b0);
  endtask

  task automatic test_reset_mid_edit();
    press(0);
    press(1);
    chk_time("pre_reset_edit", 2, 0, 1);
    rst = 1'b1;
    step();
    chk_time("mid_edit_reset_time", 0, 0, 0);
    chk_mode("mid_edit_reset_mode", 0, 1'b0);
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_set_sequence();
    test_held_key();
    test_simultaneous();
    test_rollover();
    test_edit_wrap();
    test_tick_and_mode();
    test_timeout();
    test_press_beats_timeout();
    test_reset_mid_edit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
